// File: rtl/xrouter_pkg.sv
// Shared definitions for the router slice: arbiter state encoding, port
// count and the position of the destination field inside a FIFO word.
package xrouter_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SERVE = 1'b1
  } state_t;

  localparam int NPORT    = 4;
  localparam int WORD_W   = 10;
  localparam int DEST_MSB = 9;
  localparam int DEST_LSB = 8;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
// Ports:
//   req     - request vector, one bit per input port
//   last    - last served port; search starts at last+1
//   grant   - first requesting port found, wrapping modulo NPORT
//   any_req - high when at least one request bit is set
module rr_pick
  import xrouter_pkg::*;
(
  input  logic [NPORT-1:0] req,
  input  logic [1:0]       last,
  output logic [1:0]       grant,
  output logic             any_req
);

  logic [1:0] idx;
  logic       found;

  // Offsets 1..4 visit last+1 .. last+4; offset 4 wraps back to last itself,
  // so the previously served port is considered only after all others.
  always_comb begin
    grant   = '0;
    found   = 1'b0;
    idx     = '0;
    any_req = |req;
    for (int i = 1; i <= NPORT; i++) begin
      idx = last + 2'(i);
      if (!found && req[idx]) begin
        grant = idx;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/xarbiter_rr.sv
// Round-robin arbiter for the four-input FIFO mux stage. Selects one
// non-empty input FIFO, holds the mux select on it and moves up to BURST
// words per grant, pausing on an almost-full destination and releasing a
// grant that stays paused for STALL_MAX cycles.
// Ports:
//   clk        - clock, rising edge
//   reset      - asynchronous active-high reset
//   fifo_empty - empty flags of input FIFOs 0..3
//   fifo_pause - almost-full flags of destination FIFOs 0..3
//   destino    - destination field of the selected head word
//   demux      - registered mux select (current grant)
//   pop        - one-hot pop to input FIFOs (combinational)
//   push       - one-hot push to destination FIFOs (combinational)
//   active     - high while serving a grant
module xarbiter_rr
  import xrouter_pkg::*;
#(
  parameter int BURST     = 4,
  parameter int STALL_MAX = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NPORT-1:0] fifo_empty,
  input  logic [NPORT-1:0] fifo_pause,
  input  logic [1:0]       destino,
  output logic [1:0]       demux,
  output logic [NPORT-1:0] pop,
  output logic [NPORT-1:0] push,
  output logic             active
);

  localparam logic [3:0] CNT_LAST   = 4'(BURST - 1);
  localparam logic [3:0] STALL_LAST = 4'(STALL_MAX - 1);

  state_t     state;
  logic [1:0] grant;
  logic [1:0] last;
  logic [3:0] cnt;
  logic [3:0] stall;

  logic [1:0] pick;
  logic       any_req;
  logic       xfer;

  rr_pick u_pick (
    .req     (~fifo_empty),
    .last    (last),
    .grant   (pick),
    .any_req (any_req)
  );

  // Show-ahead FIFOs: the head word is already on the mux output, so a
  // transfer is just the pop/push pair in the same cycle.
  assign xfer = (state == SERVE) && !fifo_empty[grant] && !fifo_pause[destino];

  always_comb begin
    pop  = '0;
    push = '0;
    if (xfer) begin
      pop[grant]    = 1'b1;
      push[destino] = 1'b1;
    end
  end

  assign demux  = grant;
  assign active = (state == SERVE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      grant <= 2'd0;
      last  <= 2'd3;
      cnt   <= 4'd0;
      stall <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            grant <= pick;
            cnt   <= 4'd0;
            stall <= 4'd0;
            state <= SERVE;
          end
        end
        SERVE: begin
          // Exit priority: source ran dry, burst complete, stall timeout.
          if (fifo_empty[grant]) begin
            state <= IDLE;
            last  <= grant;
          end else if (xfer) begin
            if (cnt == CNT_LAST) begin
              state <= IDLE;
              last  <= grant;
            end else begin
              cnt   <= cnt + 4'd1;
              stall <= 4'd0;
            end
          end else if (stall == STALL_LAST) begin
            state <= IDLE;
            last  <= grant;
          end else begin
            stall <= stall + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xarbiter_rr.sv
// Directed bench for xarbiter_rr with BURST=4, STALL_MAX=8.
module tb_xarbiter_rr;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] fifo_empty = 4'b1111;
  logic [3:0] fifo_pause = 4'b0000;
  logic [1:0] destino = 2'd0;
  logic [1:0] demux;
  logic [3:0] pop;
  logic [3:0] push;
  logic       active;

  int n_chk  = 0;
  int n_pass = 0;
  int stepno = 0;
  int lv [4] = '{0, 0, 0, 0};

  xarbiter_rr #(.BURST(4), .STALL_MAX(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .fifo_empty (fifo_empty),
    .fifo_pause (fifo_pause),
    .destino    (destino),
    .demux      (demux),
    .pop        (pop),
    .push       (push),
    .active     (active)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    else
      n_pass++;
  endtask

  task automatic set_empty();
    for (int i = 0; i < 4; i++) fifo_empty[i] = (lv[i] == 0);
  endtask

  // One clock cycle: apply inputs, check outputs mid-cycle, consume the
  // words the expected pops remove, then advance to just past the edge.
  task automatic step(input string tag, input logic [1:0] d, input logic [3:0] pz,
                      input logic [1:0] e_demux, input logic [3:0] e_pop,
                      input logic [3:0] e_push, input logic e_act);
    string t;
    destino    = d;
    fifo_pause = pz;
    set_empty();
    #2;
    t = $sformatf("%s_s%0d", tag, stepno);
    check({t, "_demux"},  {6'd0, demux},  {6'd0, e_demux});
    check({t, "_pop"},    {4'd0, pop},    {4'd0, e_pop});
    check({t, "_push"},   {4'd0, push},   {4'd0, e_push});
    check({t, "_active"}, {7'd0, active}, {7'd0, e_act});
    for (int i = 0; i < 4; i++) if (e_pop[i] && lv[i] > 0) lv[i]--;
    stepno++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    for (int i = 0; i < 4; i++) lv[i] = 0;
    set_empty();
    fifo_pause = 4'b0000;
    destino    = 2'd0;
    reset      = 1'b1;
    @(posedge clk);
    #1;
    check("rst_demux",  {6'd0, demux},  8'd0);
    check("rst_pop",    {4'd0, pop},    8'd0);
    check("rst_active", {7'd0, active}, 8'd0);
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] prev;
    logic [1:0] order [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

    // Idle with everything empty
    do_reset();
    for (int k = 0; k < 10; k++) step("idle", 2'd0, 4'b0000, 2'd0, 4'b0000, 4'b0000, 1'b0);

    // FIFO2 only, 6 words to destination 1
    lv[2] = 6;
    step("f2", 2'd1, 4'b0000, 2'd0, 4'b0000, 4'b0000, 1'b0);
    for (int k = 0; k < 4; k++) step("f2", 2'd1, 4'b0000, 2'd2, 4'b0100, 4'b0010, 1'b1);
    step("f2", 2'd1, 4'b0000, 2'd2, 4'b0000, 4'b0000, 1'b0);
    for (int k = 0; k < 2; k++) step("f2", 2'd1, 4'b0000, 2'd2, 4'b0100, 4'b0010, 1'b1);
    step("f2", 2'd1, 4'b0000, 2'd2, 4'b0000, 4'b0000, 1'b1);
    step("f2", 2'd1, 4'b0000, 2'd2, 4'b0000, 4'b0000, 1'b0);

    // All four busy: grant order 0,1,2,3,0 with one IDLE cycle between
    do_reset();
    for (int i = 0; i < 4; i++) lv[i] = 100;
    prev = 2'd0;
    for (int g = 0; g < 5; g++) begin
      step("rr", 2'd0, 4'b0000, prev, 4'b0000, 4'b0000, 1'b0);
      for (int k = 0; k < 4; k++)
        step("rr", 2'd0, 4'b0000, order[g], 4'(1 << order[g]), 4'b0001, 1'b1);
      prev = order[g];
    end

    // FIFO1 stalled on destination 3 until release, then FIFO2
    do_reset();
    lv[1] = 5;
    lv[2] = 5;
    step("stl", 2'd3, 4'b1000, 2'd0, 4'b0000, 4'b0000, 1'b0);
    for (int k = 0; k < 8; k++) step("stl", 2'd3, 4'b1000, 2'd1, 4'b0000, 4'b0000, 1'b1);
    step("stl", 2'd3, 4'b1000, 2'd1, 4'b0000, 4'b0000, 1'b0);
    step("stl", 2'd3, 4'b0000, 2'd2, 4'b0100, 4'b1000, 1'b1);

    // Pause for 3 cycles mid-burst; destination changes mid-grant
    do_reset();
    lv[0] = 10;
    step("pz", 2'd0, 4'b0000, 2'd0, 4'b0000, 4'b0000, 1'b0);
    step("pz", 2'd0, 4'b0000, 2'd0, 4'b0001, 4'b0001, 1'b1);
    for (int k = 0; k < 3; k++) step("pz", 2'd0, 4'b0001, 2'd0, 4'b0000, 4'b0000, 1'b1);
    step("pz", 2'd2, 4'b0001, 2'd0, 4'b0001, 4'b0100, 1'b1);
    step("pz", 2'd0, 4'b0000, 2'd0, 4'b0001, 4'b0001, 1'b1);
    step("pz", 2'd0, 4'b0000, 2'd0, 4'b0001, 4'b0001, 1'b1);
    step("pz", 2'd0, 4'b0000, 2'd0, 4'b0000, 4'b0000, 1'b0);

    // Reset during the second word of a burst
    do_reset();
    lv[1] = 10;
    step("ar", 2'd0, 4'b0000, 2'd0, 4'b0000, 4'b0000, 1'b0);
    step("ar", 2'd0, 4'b0000, 2'd1, 4'b0010, 4'b0001, 1'b1);
    set_empty();
    #2;
    check("ar_pre_pop", {4'd0, pop}, 8'b0010);
    reset = 1'b1;
    #1;
    check("ar_mid_pop",    {4'd0, pop},    8'd0);
    check("ar_mid_push",   {4'd0, push},   8'd0);
    check("ar_mid_active", {7'd0, active}, 8'd0);
    check("ar_mid_demux",  {6'd0, demux},  8'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    lv[0] = 10;
    lv[1] = 10;
    step("ar", 2'd0, 4'b0000, 2'd0, 4'b0000, 4'b0000, 1'b0);
    step("ar", 2'd0, 4'b0000, 2'd0, 4'b0001, 4'b0001, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/xarbiter_rr.md
# xarbiter_rr

Round-robin arbiter that drives the select of the four-input FIFO mux stage and generates its FIFO pops and destination FIFO pushes. It sits upstream of the mux: it picks one non-empty input FIFO, holds the mux on it, and transfers up to BURST words per grant. It pauses while the head word's destination FIFO is almost full, and releases a stalled grant so other inputs are not blocked indefinitely.

## Interface
Parameters:
- BURST, 4: maximum words transferred per grant; legal range 1..16.
- STALL_MAX, 8: consecutive paused cycles before a grant is released; legal range 1..15.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- fifo_empty  input  4  empty flags of input FIFOs 0..3.
- fifo_pause  input  4  almost-full flags of destination FIFOs 0..3.
- destino  input  2  destination field [9:8] of the currently selected head word, returned by the mux stage.
- demux  output  2  registered select of the granted input FIFO, driven to the mux stage.
- pop  output  4  one-hot pop to the input FIFOs; combinational.
- push  output  4  one-hot push to the destination FIFOs; combinational.
- active  output  1  high while in SERVE.

## Operation
- States: IDLE, SERVE.
- Registers:
  - grant[1:0] (drives demux)
  - last[1:0] (last served port)
  - cnt[3:0] (words this grant)
  - stall[3:0] (consecutive paused cycles)
- Reset values: state=IDLE, grant=0, last=3, cnt=0, stall=0. This gives demux=0, pop=0, push=0, active=0.
- IDLE:
  - If any fifo_empty bit is 0, grant <= the first non-empty port searching (last+1), (last+2), … mod 4. Next state is SERVE; cnt and stall are cleared.
  - Otherwise stay in IDLE; grant is unchanged.
- SERVE:
  - xfer = !fifo_empty[grant] && !fifo_pause[destino].
  - pop[grant] = xfer; push[destino] = xfer. All other pop/push bits are 0.
  - The mux output word is valid in the same cycle (show-ahead FIFOs), so the word is moved by the pop/push pair.
- Leaving SERVE: the first matching rule, in priority order, applies.
  1. fifo_empty[grant]=1: go to IDLE, last <= grant. No transfer this cycle.
  2. xfer and cnt==BURST-1: go to IDLE, last <= grant.
  3. xfer: cnt <= cnt+1, stall <= 0.
  4. Paused (not xfer, not empty):
     - If stall==STALL_MAX-1, go to IDLE with last <= grant.
     - Otherwise stall <= stall+1.
- In IDLE, pop and push are all 0.
- cnt and stall never wrap: each resets on entry to SERVE and exits at its terminal value.
- destino changing mid-grant (head words bound for different destinations) is legal. The pause check and the push are always evaluated against the current destino.
- Reset asserted mid-transfer: state goes to IDLE immediately (asynchronously), and pop/push drop in the same cycle. The partially served burst is not resumed; arbitration after reset starts at port 0.

## Timing
- Grant latency: a FIFO going non-empty while in IDLE gets demux updated at the next edge. Its first pop/push occurs in the cycle after that edge, i.e. 1 cycle minimum.
- Throughput within a grant is 1 word per cycle while not paused.
- Re-arbitration cost is 1 IDLE cycle between grants.
- A burst with no pause therefore occupies BURST cycles plus 1 IDLE cycle.
- fifo_pause is sampled combinationally in the same cycle as push. The destination FIFO's almost-full threshold must absorb 1 in-flight word.
- demux is stable for the whole SERVE period.
- pop/push are combinational from registered state and the current fifo_empty, fifo_pause and destino.

## Structure
- Shared package xrouter_pkg holds:
  - state enum {IDLE, SERVE}
  - NPORT=4
  - WORD_W=10
  - DEST_MSB=9, DEST_LSB=8
- Sub-module rr_pick: combinational round-robin picker. Inputs are a 4-bit request vector and last[1:0]; outputs are grant[1:0] and any_req. It is instantiated once, in the IDLE logic.

## Test plan
- Reset, then fifo_empty=4'b1111 for 10 cycles: demux=0, pop=push=0, active=0 throughout.
- Only FIFO2 non-empty, holding 6 words to destino=1, no pause, BURST=4: demux=2 one cycle later, then:
  - pop=4'b0100 and push=4'b0010 for 4 cycles
  - 1 IDLE cycle
  - 2 more words
  - fifo_empty[2]=1, return to IDLE
- All four FIFOs non-empty with continuous data: grant order is 0,1,2,3,0. Each grant gives exactly BURST pops, with 1 IDLE cycle between grants.
- FIFO1 granted, destino=3, fifo_pause[3]=1 held: zero pushes for STALL_MAX cycles, then IDLE, then grant moves to the next non-empty port (2).
- Pause on destino=0 drops after 3 cycles: transfers resume, cnt is preserved, and the burst completes at BURST total words.
- Assert reset during the 2nd word of a burst: pop/push go to 0 in the same cycle; after release, demux=0, state=IDLE, and arbitration starts from port 0.
